// File: rtl/operand_loader.sv
// Operand loader: synchronises and debounces the load button, then captures x and y
// from the switches and enables the comparators. Debounce is built when LOADER_DEBOUNCE_EN is defined.
module operand_loader #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             btn_load,
    input  logic             clr,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic             en_out,
    output logic [1:0]       state_out
);

    typedef enum logic [1:0] {
        ST_WAIT_X = 2'b00,
        ST_WAIT_Y = 2'b01,
        ST_VALID  = 2'b10,
        ST_UNUSED = 2'b11
    } state_t;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic r_sync1;
    logic r_sync2;
    logic r_db_d;
    logic w_db;
    logic w_load;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db_d  <= 1'b0;
        end else begin
            r_sync1 <= btn_load;
            r_sync2 <= r_sync1;
            r_db_d  <= w_db;
        end
    end

`ifdef LOADER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    // The level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync2 == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_db = r_db;
`else
    assign w_db = r_sync2;
`endif

    assign w_load = w_db & ~r_db_d;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] w_x_nxt;
    logic [WIDTH-1:0] w_y_nxt;
    logic             r_en;
    logic             w_en_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT_X;
            r_x     <= '0;
            r_y     <= '0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_en    <= w_en_nxt;
        end
    end

    // NOTE: every next-state signal gets a hold default first, so no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_en_nxt    = r_en;
        // clr beats a coincident load; the illegal encoding recovers the same way.
        if (clr || r_state == ST_UNUSED) begin
            w_state_nxt = ST_WAIT_X;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_en_nxt    = 1'b0;
        end else if (w_load) begin
            case (r_state)
                ST_WAIT_X: begin
                    w_x_nxt     = sw_in;
                    w_state_nxt = ST_WAIT_Y;
                end
                ST_WAIT_Y: begin
                    w_y_nxt     = sw_in;
                    w_en_nxt    = 1'b1;
                    w_state_nxt = ST_VALID;
                end
                ST_VALID: begin
                    w_x_nxt     = sw_in;
                    w_en_nxt    = 1'b0;
                    w_state_nxt = ST_WAIT_Y;
                end
                default: w_state_nxt = ST_WAIT_X;
            endcase
        end
    end

    assign x_out     = r_x;
    assign y_out     = r_y;
    assign en_out    = r_en;
    assign state_out = r_state;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: directed scenarios plus random presses,
// compared against a window-based behavioural model of synchroniser, debounce and loader.
module tb_operand_loader;

    localparam int DC = 4;
`ifdef LOADER_DEBOUNCE_EN
    localparam int   LAT      = 2 + DC;
    localparam logic GLITCH   = 1'b0;
    localparam int   PULSE_X  = 0;
`else
    localparam int   LAT      = 2;
    localparam logic GLITCH   = 1'b1;
    localparam int   PULSE_X  = 5;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw_in;
    logic       btn_load;
    logic       clr;
    logic [3:0] x_out;
    logic [3:0] y_out;
    logic       en_out;
    logic [1:0] state_out;

    int n_checks = 0;
    int n_pass   = 0;

    operand_loader #(.WIDTH(4), .DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_in     (sw_in),
        .btn_load  (btn_load),
        .clr       (clr),
        .x_out     (x_out),
        .y_out     (y_out),
        .en_out    (en_out),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic       m_s1, m_s2, m_db, m_db_d;
    bit         hist[$];
    logic [3:0] m_x, m_y;
    logic       m_en;
    logic [1:0] m_st;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_db_d = 0;
        hist.delete();
        m_x = 0; m_y = 0; m_en = 0; m_st = 2'b00;
    endtask

    // Applies one rising edge to the model using the pre-edge values.
    task automatic model_edge();
        bit db_now, db_next, load, all_diff;
`ifdef LOADER_DEBOUNCE_EN
        db_now  = m_db;
        db_next = m_db;
        hist.push_back(m_s2);
        if (hist.size() > DC) void'(hist.pop_front());
        if (hist.size() == DC) begin
            all_diff = 1;
            foreach (hist[i]) if (hist[i] == m_db) all_diff = 0;
            if (all_diff) db_next = m_s2;
        end
`else
        db_now  = m_s2;
        db_next = 0;
`endif
        load   = db_now & ~m_db_d;
        m_db_d = db_now;
        m_db   = db_next;
        m_s2   = m_s1;
        m_s1   = btn_load;
        if (clr) begin
            m_x = 0; m_y = 0; m_en = 0; m_st = 2'b00;
        end else if (load) begin
            if (m_st == 2'b00) begin
                m_x = sw_in; m_st = 2'b01;
            end else if (m_st == 2'b01) begin
                m_y = sw_in; m_en = 1; m_st = 2'b10;
            end else begin
                m_x = sw_in; m_en = 0; m_st = 2'b01;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_x", x_out, m_x);
        check("model_y", y_out, m_y);
        check("model_en", en_out, m_en);
        check("model_state", state_out, m_st);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 0; btn_load = 0; clr = 0; sw_in = 0;
        model_reset();
        #12;
        check("reset_x", x_out, 0);
        check("reset_y", y_out, 0);
        check("reset_en", en_out, 0);
        check("reset_state", state_out, 0);
        rst_n = 1;
        idle(2);

        // Basic load pair
        sw_in = 4'h9; btn_load = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == LAT - 1) check("pair_x_early", state_out, 2'b00);
            if (i == LAT) begin
                check("pair_x", x_out, 4'h9);
                check("pair_state_y", state_out, 2'b01);
            end
        end
        btn_load = 0; idle(10);
        sw_in = 4'h3; btn_load = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == LAT - 1) check("pair_en_early", en_out, 0);
            if (i == LAT) begin
                check("pair_y", y_out, 4'h3);
                check("pair_en", en_out, 1);
                check("pair_state_valid", state_out, 2'b10);
            end
        end
        btn_load = 0; idle(10);

        // Glitch rejection, then a long held press
        clr = 1; step(); clr = 0;
        sw_in = 4'h9; btn_load = 1; idle(3);
        btn_load = 0; idle(10);
        check("glitch_state", state_out, {1'b0, GLITCH});
        clr = 1; step(); clr = 0;
        btn_load = 1; idle(50);
        btn_load = 0; idle(10);
        check("held_state", state_out, 2'b01);
        check("held_x", x_out, 4'h9);
        sw_in = 4'h3; btn_load = 1; idle(10);
        btn_load = 0; idle(10);
        check("held_pair_state", state_out, 2'b10);

        // Restart from VALID
        sw_in = 4'hF; btn_load = 1; idle(10);
        btn_load = 0; idle(10);
        check("restart_x", x_out, 4'hF);
        check("restart_en", en_out, 0);
        check("restart_state", state_out, 2'b01);
        check("restart_y_kept", y_out, 4'h3);

        // clr coinciding with load in WAIT_Y
        sw_in = 4'h7; btn_load = 1;
        for (int i = 0; i < 10; i++) begin
            clr = (i == LAT);
            step();
            if (i == LAT) begin
                check("clr_x", x_out, 0);
                check("clr_y", y_out, 0);
                check("clr_en", en_out, 0);
                check("clr_state", state_out, 2'b00);
            end
        end
        clr = 0; btn_load = 0; idle(10);
        check("clr_no_capture", state_out, 2'b00);

        // Async reset mid-count
        sw_in = 4'hA; btn_load = 1; idle(10);
        btn_load = 0; idle(10);
        sw_in = 4'hC; btn_load = 1; idle(3);
        #2 rst_n = 0;
        #1;
        check("arst_x", x_out, 0);
        check("arst_state", state_out, 2'b00);
        model_reset();
        #2 rst_n = 1;
        for (int i = 0; i < LAT + 3; i++) begin
            step();
            if (i == LAT - 1) check("arst_x_early", x_out, 0);
            if (i == LAT) begin
                check("arst_x_fresh", x_out, 4'hC);
                check("arst_state_fresh", state_out, 2'b01);
            end
        end
        btn_load = 0; idle(10);

        // Single-cycle pulse
        clr = 1; step(); clr = 0;
        sw_in = 4'h5; btn_load = 1; step();
        btn_load = 0;
        for (int i = 1; i < 6; i++) begin
            step();
            if (i == 2) check("pulse_x", x_out, PULSE_X);
        end

        // Random presses, gaps and occasional clr against the model
        for (int k = 0; k < 30; k++) begin
            int len;
            sw_in = 4'($urandom);
            len = $urandom_range(1, 8);
            btn_load = 1;
            for (int i = 0; i < len; i++) begin
                clr = ($urandom_range(0, 15) == 0);
                step();
            end
            clr = 0;
            btn_load = 0;
            len = $urandom_range(1, 8);
            idle(len);
        end
        idle(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
